spsa_coeff_updater: RTL and testbench

Adaptive SPSA coefficient engine for the DPD loop. It is the consumer of the Q8.8 NMSE error metric stream. For each iteration it applies a +c·Δ perturbation to the DPD coefficient set, waits for the metric to settle, and captures J+. It then applies −c·Δ and captures J−. Finally it updates every coefficient by a sign-scaled gradient step. The block holds the nominal (θ) and active (DPD-visible) coefficient banks and sits between the error-metric calculator and the DPD datapath.

---
 rtl/spsa_pkg.sv | 36 +++
 rtl/spsa_lfsr16.sv | 21 ++
 rtl/spsa_coeff_updater.sv | 216 +++++++++++++++++++++
 tb/tb_spsa_coeff_updater.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spsa_pkg.sv
// Shared state encoding, LFSR polynomial and Q1.15 saturation helper for the
// SPSA coefficient engine.
package spsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY_P,
        ST_SETTLE_P,
        ST_APPLY_M,
        ST_SETTLE_M,
        ST_UPDATE,
        ST_ABORT
    } spsa_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    localparam logic signed [17:0] SUM_MAX = 18'sd32767;
    localparam logic signed [17:0] SUM_MIN = -18'sd32768;

    // Operands arrive already sign-extended to 18 bits, so the sum cannot wrap.
    function automatic logic signed [15:0] sat_add(input logic signed [17:0] a,
                                                   input logic signed [17:0] b);
        logic signed [17:0] sum;
        sum = a + b;
        if (sum > SUM_MAX) begin
            return Q15_MAX;
        end else if (sum < SUM_MIN) begin
            return Q15_MIN;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/spsa_lfsr16.sv
// 16-bit Galois LFSR producing the SPSA perturbation sign vector.
module spsa_lfsr16
    import spsa_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/spsa_coeff_updater.sv
// SPSA coefficient engine: perturb +c/-c, capture J+/J-, sign-scaled update.
// Optional SPSA_GAIN_DECAY_EN halves the step every 1024 iterations.
module spsa_coeff_updater
    import spsa_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           NUM_COEFFS     = 8,
    parameter int unsigned           IDX_WIDTH      = 3,
    parameter int unsigned           SETTLE_SAMPLES = 64,
    parameter int unsigned           CNT_WIDTH      = 8,
    parameter logic signed [DATA_WIDTH-1:0] C_PERT  = 16'sh0040,
    parameter int unsigned           MU_SHIFT       = 4,
    parameter logic [15:0]           LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] metric,
    input  logic                         metric_valid,
    input  logic                         cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]         cfg_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic [IDX_WIDTH-1:0]         coeff_rd_addr,
    output logic signed [DATA_WIDTH-1:0] coeff_rd_data,
    output logic                         busy,
    output logic                         update_done,
    output logic [15:0]                  iter_count,
    output logic signed [DATA_WIDTH:0]   last_diff
);

    // Banks are sized to the full address space so unused slots read as zero.
    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    spsa_state_t state;

    logic signed [DATA_WIDTH-1:0] theta  [DEPTH];
    logic signed [DATA_WIDTH-1:0] active [DEPTH];

    logic [NUM_COEFFS-1:0]        delta;
    logic [IDX_WIDTH-1:0]         idx;
    logic [CNT_WIDTH-1:0]         settle_cnt;
    logic signed [DATA_WIDTH-1:0] j_plus;
    logic signed [DATA_WIDTH-1:0] j_minus;

    logic [15:0] lfsr_state;
    logic        lfsr_adv;
    logic        lfsr_unused;
    logic        last_idx;

    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH:0]   step;
    logic [7:0]                   shift_amt;
    logic signed [DATA_WIDTH+1:0] theta_k;
    logic signed [DATA_WIDTH+1:0] c_ext;
    logic signed [DATA_WIDTH+1:0] step_ext;
    logic signed [DATA_WIDTH+1:0] pert;
    logic signed [DATA_WIDTH-1:0] apply_val;
    logic signed [DATA_WIDTH-1:0] update_val;

    spsa_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .advance(lfsr_adv),
        .state  (lfsr_state)
    );

    // Only the low NUM_COEFFS bits feed delta; the rest just keep the sequence.
    assign lfsr_unused = ^lfsr_state;

    assign last_idx = (idx == IDX_WIDTH'(NUM_COEFFS - 1));

    assign lfsr_adv = enable && ((state == ST_IDLE) ||
                                 ((state == ST_UPDATE) && last_idx));

    assign coeff_rd_data = active[coeff_rd_addr];

    assign diff = $signed({j_plus[DATA_WIDTH-1], j_plus}) -
                  $signed({j_minus[DATA_WIDTH-1], j_minus});

`ifdef SPSA_GAIN_DECAY_EN
    logic [5:0] decay;

    always_comb begin
        decay = iter_count[15:10];
        if (decay > 6'd6) begin
            decay = 6'd6;
        end
        shift_amt = 8'(MU_SHIFT) + {2'b00, decay};
    end
`else
    always_comb begin
        shift_amt = 8'(MU_SHIFT);
    end
`endif

    assign step = diff >>> shift_amt;

    always_comb begin
        theta_k    = {{2{theta[idx][DATA_WIDTH-1]}}, theta[idx]};
        c_ext      = {{2{C_PERT[DATA_WIDTH-1]}}, C_PERT};
        step_ext   = {step[DATA_WIDTH], step};
        pert       = (delta[idx] ^ (state == ST_APPLY_M)) ? c_ext : -c_ext;
        apply_val  = sat_add(theta_k, pert);
        update_val = sat_add(theta_k, delta[idx] ? -step_ext : step_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            settle_cnt  <= '0;
            delta       <= '0;
            j_plus      <= '0;
            j_minus     <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            iter_count  <= '0;
            last_diff   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                theta[i]  <= '0;
                active[i] <= '0;
            end
        end else begin
            update_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_wr_en) begin
                        theta[cfg_wr_addr]  <= cfg_wr_data;
                        active[cfg_wr_addr] <= cfg_wr_data;
                    end
                    if (enable) begin
                        delta <= lfsr_state[NUM_COEFFS-1:0];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_APPLY_P;
                    end
                end

                ST_APPLY_P, ST_APPLY_M: begin
                    settle_cnt <= '0;
                    if (!enable) begin
                        idx   <= '0;
                        state <= ST_ABORT;
                    end else begin
                        active[idx] <= apply_val;
                        if (last_idx) begin
                            idx   <= '0;
                            state <= (state == ST_APPLY_P) ? ST_SETTLE_P : ST_SETTLE_M;
                        end else begin
                            idx <= idx + IDX_WIDTH'(1);
                        end
                    end
                end

                ST_SETTLE_P, ST_SETTLE_M: begin
                    if (!enable) begin
                        idx   <= '0;
                        state <= ST_ABORT;
                    end else if (metric_valid) begin
                        if (settle_cnt == CNT_WIDTH'(SETTLE_SAMPLES)) begin
                            settle_cnt <= '0;
                            if (state == ST_SETTLE_P) begin
                                j_plus <= metric;
                                state  <= ST_APPLY_M;
                            end else begin
                                j_minus <= metric;
                                state   <= ST_UPDATE;
                            end
                        end else begin
                            settle_cnt <= settle_cnt + CNT_WIDTH'(1);
                        end
                    end
                end

                // Runs to completion regardless of enable; enable only picks the exit.
                ST_UPDATE: begin
                    theta[idx]  <= update_val;
                    active[idx] <= update_val;
                    last_diff   <= diff;
                    if (last_idx) begin
                        idx         <= '0;
                        iter_count  <= iter_count + 16'd1;
                        update_done <= 1'b1;
                        if (enable) begin
                            delta <= lfsr_state[NUM_COEFFS-1:0];
                            state <= ST_APPLY_P;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end

                ST_ABORT: begin
                    active[idx] <= theta[idx];
                    if (last_idx) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spsa_coeff_updater.sv
// Self-checking bench for spsa_coeff_updater: vector table of J+/J- pairs,
// reference model with expected-result queue, plus abort and reset sequences.
module tb_spsa_coeff_updater;

    localparam int N = 8;
    localparam int S = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic signed [15:0]  metric;
    logic                metric_valid;
    logic                cfg_wr_en;
    logic [2:0]          cfg_wr_addr;
    logic signed [15:0]  cfg_wr_data;
    logic [2:0]          coeff_rd_addr;
    logic signed [15:0]  coeff_rd_data;
    logic                busy;
    logic                update_done;
    logic [15:0]         iter_count;
    logic signed [16:0]  last_diff;

    spsa_coeff_updater #(
        .DATA_WIDTH    (16),
        .NUM_COEFFS    (N),
        .IDX_WIDTH     (3),
        .SETTLE_SAMPLES(S),
        .CNT_WIDTH     (8),
        .C_PERT        (16'sh0040),
        .MU_SHIFT      (4),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .metric       (metric),
        .metric_valid (metric_valid),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .coeff_rd_addr(coeff_rd_addr),
        .coeff_rd_data(coeff_rd_data),
        .busy         (busy),
        .update_done  (update_done),
        .iter_count   (iter_count),
        .last_diff    (last_diff)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic signed [15:0] jp;
        logic signed [15:0] jm;
        int                 exp_diff;
        logic               cont;
    } vec_t;

    typedef struct packed {
        logic [15:0]    iter;
        logic [16:0]    diff;
        logic [N*16-1:0] theta;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    logic signed [15:0] init_theta [N] = '{16'sh1000, 16'sh8005, 16'sh0200, 16'shFF00,
                                           16'sh0000, 16'sh4000, 16'shC000, 16'sh7FF0};
    logic signed [15:0] theta_m [N];
    logic signed [15:0] rd      [N];
    logic signed [15:0] snap_p  [N];
    logic signed [15:0] snap_m  [N];
    logic [15:0]        lfsr_m;
    logic [N-1:0]       delta_m;
    int                 iter_m;
    int                 done_cnt = 0;
    int                 checks = 0;
    int                 errors = 0;

    always @(negedge clk) begin
        if (update_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic signed [15:0] sat16(input int v);
        if (v > 32767) return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
        return 16'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) theta_m[k] = 16'sh0000;
        lfsr_m = SEED;
        iter_m = 0;
    endtask

    task automatic model_start();
        delta_m = lfsr_m[N-1:0];
        lfsr_m  = lfsr_next(lfsr_m);
    endtask

    task automatic read_all();
        for (int i = 0; i < N; i++) begin
            coeff_rd_addr = 3'(i);
            #1;
            rd[i] = coeff_rd_data;
        end
    endtask

    // Entered at the negedge where the DUT sits in an APPLY state at index 0.
    task automatic apply_phase(input bit neg, input string tag);
        for (int c = 0; c < N; c++) begin
            metric_valid = 1'b1;
            metric       = 16'sh5A5A + 16'(c);
            @(negedge clk);
        end
        read_all();
        for (int k = 0; k < N; k++) begin
            int p = (delta_m[k] ^ neg) ? 64 : -64;
            chk($sformatf("%s_active%0d", tag, k), rd[k], sat16(int'(theta_m[k]) + p));
            if (neg) snap_m[k] = rd[k];
            else     snap_p[k] = rd[k];
        end
    endtask

    // S discarded pulses separated by idle gaps, then the pulse to be latched.
    task automatic settle_phase(input logic signed [15:0] val);
        for (int p = 0; p < S; p++) begin
            metric_valid = 1'b1;
            metric       = 16'sh7000 - 16'(p);
            if (p == 0) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = 3'd2;
                cfg_wr_data = 16'sh5555;
            end
            @(negedge clk);
            cfg_wr_en    = 1'b0;
            metric_valid = 1'b0;
            metric       = 16'sh6666;
            @(negedge clk);
        end
        metric_valid = 1'b1;
        metric       = val;
        @(negedge clk);
    endtask

    task automatic run_iter(input vec_t v, input string tag);
        exp_t e;
        int   diff;
        int   step;
        int   waited;
        apply_phase(1'b0, {tag, "_p"});
        settle_phase(v.jp);
        apply_phase(1'b1, {tag, "_m"});
        diff = int'(v.jp) - int'(v.jm);
        step = diff >>> 4;
        for (int k = 0; k < N; k++) begin
            theta_m[k] = sat16(int'(theta_m[k]) - (delta_m[k] ? step : -step));
            e.theta[k*16 +: 16] = theta_m[k];
        end
        iter_m++;
        e.iter = 16'(iter_m);
        e.diff = 17'(diff);
        sb.push_back(e);
        if (v.cont) model_start();
        settle_phase(v.jm);
        enable       = v.cont;
        metric_valid = 1'b0;
        waited = 0;
        while (update_done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_done_latency"}, waited, 8);
        chk({tag, "_done_seen"}, update_done, 1);
        chk({tag, "_diff_table"}, last_diff, v.exp_diff);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_iter"}, iter_count, e.iter);
            chk({tag, "_diff"}, last_diff, $signed(e.diff));
            read_all();
            for (int k = 0; k < N; k++)
                chk($sformatf("%s_theta%0d", tag, k), rd[k], $signed(e.theta[k*16 +: 16]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        vecs[0] = '{jp: 16'sh0200, jm: 16'sh0100, exp_diff: 256,    cont: 1'b1};
        vecs[1] = '{jp: 16'sh7FFF, jm: 16'sh8000, exp_diff: 65535,  cont: 1'b1};
        vecs[2] = '{jp: 16'sh8000, jm: 16'sh7FFF, exp_diff: -65535, cont: 1'b1};
        vecs[3] = '{jp: 16'sh0010, jm: 16'sh0010, exp_diff: 0,      cont: 1'b1};
        vecs[4] = '{jp: 16'sh0100, jm: 16'sh0300, exp_diff: -512,   cont: 1'b0};
        vecs[5] = '{jp: 16'sh0040, jm: 16'sh0000, exp_diff: 64,     cont: 1'b0};

        rst = 1'b1; enable = 1'b0; metric = '0; metric_valid = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; coeff_rd_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", update_done, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_diff", last_diff, 0);
        read_all();
        for (int k = 0; k < N; k++) chk($sformatf("rst_coeff%0d", k), rd[k], 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < N; k++) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = 3'(k); cfg_wr_data = init_theta[k];
            theta_m[k] = init_theta[k];
            @(negedge clk);
        end
        cfg_wr_en = 1'b0;
        read_all();
        for (int k = 0; k < N; k++) chk($sformatf("load%0d", k), rd[k], init_theta[k]);

        enable = 1'b1;
        @(negedge clk);
        model_start();
        chk("busy_rise", busy, 1);
        for (int i = 0; i < 5; i++) begin
            run_iter(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                chk("plan_p0",  snap_p[0], 16'sh1040);
                chk("plan_m0",  snap_m[0], 16'sh0FC0);
                chk("sat_hi7",  snap_p[7], 16'sh7FFF);
                chk("sat_lo1",  snap_p[1], 16'sh8000);
                chk("upd_th0",  rd[0],     16'sh0FF0);
                chk("upd_th1",  rd[1],     16'sh8015);
            end
        end
        chk("busy_fall", busy, 0);
        chk("done_count", done_cnt, 5);
        chk("iter_after_loop", iter_count, 5);

        // Abort during SETTLE_M: active restored from theta, nothing else moves.
        enable = 1'b1;
        @(negedge clk);
        model_start();
        apply_phase(1'b0, "ab_p");
        settle_phase(16'sh0123);
        apply_phase(1'b1, "ab_m");
        metric_valid = 1'b1; metric = 16'sh0777;
        @(negedge clk);
        enable = 1'b0; metric_valid = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_latency", waited, 9);
        chk("abort_iter", iter_count, 5);
        chk("abort_diff", last_diff, -512);
        chk("abort_done_count", done_cnt, 5);
        read_all();
        for (int k = 0; k < N; k++) chk($sformatf("abort_th%0d", k), rd[k], theta_m[k]);

        // Reset mid-iteration, then one iteration from the reseeded LFSR.
        enable = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_iter", iter_count, 0);
        chk("mid_rst_diff", last_diff, 0);
        read_all();
        for (int k = 0; k < N; k++) chk($sformatf("mid_rst_coeff%0d", k), rd[k], 0);
        enable = 1'b1;
        @(negedge clk);
        model_start();
        run_iter(vecs[5], "post_rst");
        chk("post_rst_th0", rd[0], -16'sd4);
        chk("post_rst_th1", rd[1], 16'sd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
